vram_pixel_writer: RTL
======================

VRAM_PIXEL_WRITER -- requirements
Module: vram_pixel_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the write FIFO (power of two, minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port wr_valid, input, 1, a single-pixel write request.
REQ-005 SHALL have port wr_ready, output, 1, indicating a write request is accepted this cycle.
REQ-006 SHALL have port wr_addr, input, 17, the pixel index (line*320 + x).
REQ-007 SHALL have port wr_data, input, 24, the pixel colour as {r[7:0], g[7:0], b[7:0]}.
REQ-008 SHALL have port fill_start, input, 1, a single-cycle rectangle-free linear fill request.
REQ-009 SHALL have port fill_addr, input, 17, the first pixel index of the fill.
REQ-010 SHALL have port fill_count, input, 17, the number of pixels to fill.
REQ-011 SHALL have port fill_color, input, 24, the fill colour.
REQ-012 SHALL have port busy, output, 1, high while the FSM is not in IDLE.
REQ-013 SHALL have port fill_done, output, 1, a one-cycle pulse at the end of a fill.
REQ-014 SHALL have port vram_we, output, 1, the pixel VRAM write enable.
REQ-015 SHALL have port vram_addr, output, 17, the pixel VRAM write address.
REQ-016 SHALL have port vram_d, output, 24, the pixel VRAM write data.

Function
REQ-017 SHALL treat a write as accepted on a rising edge where wr_valid=1 and wr_ready=1, and push {wr_addr, wr_data} into the FIFO.
REQ-018 SHALL drive wr_ready = (FIFO not full) AND (state != DRAIN); a full FIFO SHALL NOT accept a push even when a pop occurs in the same cycle.
REQ-019 SHALL implement FSM states IDLE, DRAIN and FILL, all with registered outputs.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop one entry per cycle and present it on vram_we/vram_addr/vram_d in the next cycle; a write accepted at edge k SHALL appear with vram_we=1 in the cycle after edge k+1, giving a throughput of 1 per cycle.
REQ-021 SHALL, in IDLE on fill_start=1, latch fill_addr, fill_count and fill_color, then go to FILL if the FIFO is empty or to DRAIN otherwise.
REQ-022 SHALL, in DRAIN, continue popping the FIFO one entry per cycle, accept no pushes, and go to FILL once the last entry has been popped.
REQ-023 SHALL, in FILL, emit one write per cycle with vram_addr = latched fill_addr + i (modulo 2^17, 17-bit wrap) for i = 0..count-1, and vram_d = latched colour.
REQ-024 SHALL, in FILL, accept FIFO pushes (subject to REQ-018) but SHALL NOT pop them until the FSM has returned to IDLE.
REQ-025 SHALL, after the last fill write, return to IDLE and pulse fill_done=1 for exactly one cycle, in the cycle after the last vram_we of the fill.
REQ-026 SHALL, for fill_count=0, perform no fill writes and pulse fill_done in the cycle immediately after the FSM enters FILL, with no vram_we.
REQ-027 SHALL ignore fill_start while in DRAIN or FILL.
REQ-028 SHALL, when fill_start and an accepted push occur at the same edge in IDLE, push the entry into the FIFO first and then go to DRAIN.
REQ-029 SHALL hold vram_we=0 in every cycle that carries no write; vram_addr and vram_d SHALL hold their last values in those cycles.
REQ-030 SHALL drive busy=1 exactly when state is DRAIN or FILL.

Reset
REQ-031 SHALL, while reset=1, immediately force state=IDLE, FIFO empty, vram_we=0, vram_addr=0, vram_d=0, fill_done=0 and busy=0; wr_ready SHALL be 1 during and after reset.
REQ-032 SHALL, on reset asserted mid-fill or mid-drain, abort the operation with no further vram_we, emit no fill_done, and discard FIFO contents.

Verification
REQ-033 SHALL be tested with a single write of addr=100, data=0xFF0000 accepted at edge k, requiring vram_we=1, vram_addr=100 and vram_d=0xFF0000 in the cycle after edge k+1 only.
REQ-034 SHALL be tested with 5 back-to-back writes and the drain stalled by a fill, requiring wr_ready=0 when 4 entries are held and no data loss or reordering after IDLE resumes.
REQ-035 SHALL be tested with fill_start, addr=76798, count=4, colour=0x00FF00, requiring writes to 76798, 76799, 76800 and 76801 on consecutive cycles, then fill_done for one cycle.
REQ-036 SHALL be tested with fill_addr=0x1FFFE and count=3, requiring addresses 0x1FFFE, 0x1FFFF and 0x00000.
REQ-037 SHALL be tested with 2 entries queued plus fill_start, requiring the state sequence DRAIN then FILL, the 2 FIFO writes before any fill write, and wr_ready=0 during DRAIN.
REQ-038 SHALL be tested with fill_count=0 and with reset asserted on the third fill cycle, requiring respectively fill_done with zero writes, and vram_we=0 with busy=0 immediately and no fill_done.

Source files
------------

// File: rtl/vram_pixel_writer_if.sv
//------------------------------------------------------------------------------
// vram_pixel_writer_if
//
// Bundles the pixel-write handshake, the linear-fill request, the status flags
// and the VRAM write port of vram_pixel_writer into one interface.
//
// Signals:
//   wr_valid    single-pixel write request
//   wr_ready    write request accepted on this cycle's rising edge
//   wr_addr     pixel index (line*320 + x)
//   wr_data     pixel colour {r[7:0], g[7:0], b[7:0]}
//   fill_start  one-cycle linear fill request
//   fill_addr   first pixel index of the fill
//   fill_count  number of pixels to fill
//   fill_color  fill colour
//   busy        writer is draining or filling
//   fill_done   one-cycle pulse at the end of a fill
//   vram_we     VRAM write enable
//   vram_addr   VRAM write address
//   vram_d      VRAM write data
//
// Modports:
//   master  the client that issues writes/fills and watches status
//   slave   the pixel writer itself
//------------------------------------------------------------------------------
interface vram_pixel_writer_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [23:0] wr_data;

  logic        fill_start;
  logic [16:0] fill_addr;
  logic [16:0] fill_count;
  logic [23:0] fill_color;

  logic        busy;
  logic        fill_done;

  logic        vram_we;
  logic [16:0] vram_addr;
  logic [23:0] vram_d;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output fill_start, fill_addr, fill_count, fill_color,
    input  wr_ready, busy, fill_done,
    input  vram_we, vram_addr, vram_d
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  fill_start, fill_addr, fill_count, fill_color,
    output wr_ready, busy, fill_done,
    output vram_we, vram_addr, vram_d
  );

endinterface

// File: rtl/vram_pixel_writer.sv
//------------------------------------------------------------------------------
// vram_pixel_writer
//
// Funnels single-pixel writes and linear colour fills into one pixel-VRAM
// write port. Single writes are buffered in a small FIFO and retired one per
// cycle. A fill first retires everything already queued (DRAIN), then writes
// fill_count consecutive pixels with one colour (FILL). Writes that arrive
// during a fill are queued and retired once the writer is back in IDLE, so the
// VRAM sees all traffic in acceptance order.
//
// Ports:
//   clk    single clock for all logic
//   reset  asynchronous, active-high; empties the FIFO and aborts any fill
//   bus    vram_pixel_writer_if.slave (handshake, fill request, status, VRAM)
//
// Parameters:
//   FIFO_DEPTH  number of FIFO entries, power of two, at least 2
//
// Timing:
//   A write accepted at edge k is popped at edge k+1 and is visible on the
//   VRAM port in the cycle after edge k+1. All VRAM-port outputs and fill_done
//   are registers; wr_ready and busy decode registered state only.
//------------------------------------------------------------------------------
module vram_pixel_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vram_pixel_writer_if.slave   bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [16:0] addr;
    logic [23:0] data;
  } entry_t;

  //----------------------------------------------------------------------------
  // State
  //----------------------------------------------------------------------------
  state_e           state_q, state_d;

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Fill engine: next address to write, pixels still to write, colour.
  logic [16:0]      fill_addr_q, fill_addr_d;
  logic [16:0]      fill_left_q, fill_left_d;
  logic [23:0]      fill_color_q, fill_color_d;

  // Registered VRAM port and done pulse.
  logic             vram_we_q, vram_we_d;
  logic [16:0]      vram_addr_q, vram_addr_d;
  logic [23:0]      vram_d_q, vram_d_d;
  logic             fill_done_q, fill_done_d;

  //----------------------------------------------------------------------------
  // FIFO control
  //----------------------------------------------------------------------------
  logic   fifo_full;
  logic   fifo_empty;
  logic   wr_ready;
  logic   push;
  logic   pop;
  entry_t head;
  entry_t wr_entry;

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == '0);

  // Readiness looks only at the current occupancy, so a full FIFO refuses a
  // push even on a cycle where it also pops.
  assign wr_ready = !fifo_full && (state_q != DRAIN);
  assign push     = bus.wr_valid && wr_ready;

  // Queued entries retire only in IDLE and DRAIN; during FILL they wait.
  assign pop      = !fifo_empty && ((state_q == IDLE) || (state_q == DRAIN));

  assign head          = fifo_mem[rd_ptr_q];
  assign wr_entry.addr = bus.wr_addr;
  assign wr_entry.data = bus.wr_data;

  // Occupancy after this edge; used to decide whether a fill must drain first.
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // NOTE: FIFO storage has no reset; the pointers and count decide which
  // entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_entry;
    end
  end

  //----------------------------------------------------------------------------
  // Next-state and output logic
  //----------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before any branch, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_left_d  = fill_left_q;
    fill_color_d = fill_color_q;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_d_d     = vram_d_q;
    fill_done_d  = 1'b0;

    // FIFO retirement; pop is never true in FILL, so this cannot collide
    // with a fill write below.
    if (pop) begin
      vram_we_d   = 1'b1;
      vram_addr_d = head.addr;
      vram_d_d    = head.data;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          fill_addr_d  = bus.fill_addr;
          fill_left_d  = bus.fill_count;
          fill_color_d = bus.fill_color;
          // A push on the same edge counts as queued, so it drains first.
          state_d      = (count_d == '0) ? FILL : DRAIN;
        end
      end

      DRAIN: begin
        // No pushes in DRAIN, so reaching zero means the last entry left.
        if (count_d == '0) begin
          state_d = FILL;
        end
      end

      FILL: begin
        if (fill_left_q != '0) begin
          vram_we_d   = 1'b1;
          vram_addr_d = fill_addr_q;
          vram_d_d    = fill_color_q;
          // 17-bit add wraps from 0x1FFFF to 0x00000.
          fill_addr_d = fill_addr_q + 17'd1;
          fill_left_d = fill_left_q - 17'd1;
        end else begin
          // One cycle after the last write (or right after entering FILL
          // for an empty fill).
          fill_done_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Registers
  //----------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fill_addr_q  <= '0;
      fill_left_q  <= '0;
      fill_color_q <= '0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_d_q     <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      fill_addr_q  <= fill_addr_d;
      fill_left_q  <= fill_left_d;
      fill_color_q <= fill_color_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_d_q     <= vram_d_d;
      fill_done_q  <= fill_done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  //----------------------------------------------------------------------------
  // Outputs
  //----------------------------------------------------------------------------
  assign bus.wr_ready  = wr_ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.fill_done = fill_done_q;
  assign bus.vram_we   = vram_we_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.vram_d    = vram_d_q;

endmodule
